// File: rtl/rank_display.sv
// Scans five 5-bit ranks onto a 5-digit common-anode 7-segment display, one digit per slot.
// Optional RANK_BLANK_ZERO_EN: a rank of zero shows a dark digit instead of '0'.
module rank_display #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 4,
   parameter int DIV_W    = 16
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic [24:0] RANK_IN,
   output logic [4:0]  AN,
   output logic [6:0]  SEG,
   output logic        FRAME_DONE
);

   localparam logic [DIV_W-1:0] PRE_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] PRE_GUARD = DIV_W'(GUARD);

   logic [DIV_W-1:0] pre_q, pre_d;
   logic [2:0]       idx_q, idx_d;
   logic [24:0]      snap_q, snap_d;
   logic [4:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             fd_q, fd_d;
   logic             tick;
   logic [4:0]       digit;

   function automatic logic [6:0] dec(input logic [4:0] v);
      logic [6:0] s;
      case (v)
`ifdef RANK_BLANK_ZERO_EN
         5'd0:    s = 7'h7F;
`else
         5'd0:    s = 7'h40;
`endif
         5'd1:    s = 7'h79;
         5'd2:    s = 7'h24;
         5'd3:    s = 7'h30;
         5'd4:    s = 7'h19;
         5'd5:    s = 7'h12;
         5'd6:    s = 7'h02;
         5'd7:    s = 7'h78;
         5'd8:    s = 7'h00;
         5'd9:    s = 7'h10;
         default: s = 7'h06;
      endcase
      return s;
   endfunction

   always_comb begin
      tick   = (pre_q == PRE_LAST);
      pre_d  = tick ? '0 : pre_q + 1'b1;
      idx_d  = idx_q;
      snap_d = snap_q;
      fd_d   = 1'b0;
      if (tick) begin
         idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
         // The whole bus is latched at frame end so a frame never mixes old and new ranks.
         if (idx_q == 3'd4) begin
            snap_d = RANK_IN;
            fd_d   = 1'b1;
         end
      end

      case (idx_q)
         3'd0:    digit = snap_q[4:0];
         3'd1:    digit = snap_q[9:5];
         3'd2:    digit = snap_q[14:10];
         3'd3:    digit = snap_q[19:15];
         default: digit = snap_q[24:20];
      endcase

      an_d  = 5'b11111;
      seg_d = 7'h7F;
      if (pre_q >= PRE_GUARD) begin
         an_d  = ~(5'b00001 << idx_q);
         seg_d = dec(digit);
      end
   end

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         pre_q  <= '0;
         idx_q  <= 3'd0;
         snap_q <= 25'h0;
         an_q   <= 5'b11111;
         seg_q  <= 7'h7F;
         fd_q   <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         fd_q   <= fd_d;
      end
   end

   assign AN         = an_q;
   assign SEG        = seg_q;
   assign FRAME_DONE = fd_q;

endmodule
